// File: rtl/universal_shift_register.sv
// Universal shift register: hold, parallel load, shift, rotate and up/down count,
// with a one-cycle carry pulse and a combinational zero flag.
module universal_shift_register #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] D,
  input  logic             sin_r,
  input  logic             sin_l,
  output logic [WIDTH-1:0] Q,
  output logic             carry,
  output logic             zero
);

  generate
    if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
      $error("universal_shift_register: WIDTH must be in 2..32");
    end
  endgenerate

  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_LOAD = 3'b001;
  localparam logic [2:0] MODE_SHL  = 3'b010;
  localparam logic [2:0] MODE_SHR  = 3'b011;
  localparam logic [2:0] MODE_ROL  = 3'b100;
  localparam logic [2:0] MODE_ROR  = 3'b101;
  localparam logic [2:0] MODE_UP   = 3'b110;
  localparam logic [2:0] MODE_DOWN = 3'b111;

  logic [WIDTH-1:0] q_next;
  logic             carry_next;

  always_comb begin
    q_next     = Q;
    carry_next = 1'b0;
    case (mode)
      MODE_HOLD: q_next = Q;
      MODE_LOAD: q_next = D;
      MODE_SHL: begin
        q_next     = {Q[WIDTH-2:0], sin_r};
        carry_next = Q[WIDTH-1];
      end
      MODE_SHR: begin
        q_next     = {sin_l, Q[WIDTH-1:1]};
        carry_next = Q[0];
      end
      MODE_ROL: begin
        q_next     = {Q[WIDTH-2:0], Q[WIDTH-1]};
        carry_next = Q[WIDTH-1];
      end
      MODE_ROR: begin
        q_next     = {Q[0], Q[WIDTH-1:1]};
        carry_next = Q[0];
      end
      MODE_UP: begin
        q_next     = Q + WIDTH'(1);
        carry_next = (Q == '1);
      end
      MODE_DOWN: begin
        q_next     = Q - WIDTH'(1);
        carry_next = (Q == '0);
      end
      default: begin
        q_next     = Q;
        carry_next = 1'b0;
      end
    endcase
  end

  // Register stage: reset wins over any operation; carry is a pulse, cleared when idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      Q     <= '0;
      carry <= 1'b0;
    end else if (en) begin
      Q     <= q_next;
      carry <= carry_next;
    end else begin
      carry <= 1'b0;
    end
  end

  assign zero = (Q == '0);

endmodule

// File: tb/tb_universal_shift_register.sv
// Bench for universal_shift_register (WIDTH=8): directed vector table, reset
// timing sequence and a randomized phase, all checked through an expectation queue.
module tb_universal_shift_register;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         en;
  logic [2:0]   mode;
  logic [W-1:0] D;
  logic         sin_r;
  logic         sin_l;
  logic [W-1:0] Q;
  logic         carry;
  logic         zero;

  universal_shift_register #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .mode (mode),
    .D    (D),
    .sin_r(sin_r),
    .sin_l(sin_l),
    .Q    (Q),
    .carry(carry),
    .zero (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         rst;
    logic         en;
    logic [2:0]   mode;
    logic [W-1:0] d;
    logic         sr;
    logic         sl;
    logic [W-1:0] eq;
    logic         ec;
    logic         ez;
  } vec_t;

  typedef struct {
    logic [W-1:0] q;
    logic         c;
    logic         z;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  localparam int NV = 36;
  vec_t tbl[NV];

  function automatic vec_t mk(input logic r, input logic e, input logic [2:0] m,
                              input logic [W-1:0] d, input logic sr, input logic sl,
                              input logic [W-1:0] eq, input logic ec, input logic ez);
    vec_t v;
    v.rst = r; v.en = e; v.mode = m; v.d = d; v.sr = sr; v.sl = sl;
    v.eq = eq; v.ec = ec; v.ez = ez;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Drive one edge's inputs at the falling edge, record the expectation, compare after the edge.
  task automatic apply(input string name, input logic r, input logic e, input logic [2:0] m,
                       input logic [W-1:0] d, input logic sr, input logic sl, input exp_t ex);
    exp_t got;
    @(negedge clk);
    rst = r; en = e; mode = m; D = d; sin_r = sr; sin_l = sl;
    exp_q.push_back(ex);
    @(posedge clk);
    #1;
    got = exp_q.pop_front();
    check({name, ".Q"}, 32'(Q), 32'(got.q));
    check({name, ".carry"}, 32'(carry), 32'(got.c));
    check({name, ".zero"}, 32'(zero), 32'(got.z));
  endtask

  // Independent reference for the randomized phase.
  logic [W-1:0] mq;
  logic         mc;

  task automatic model_step(input logic r, input logic e, input logic [2:0] m,
                            input logic [W-1:0] d, input logic sr, input logic sl);
    logic [W-1:0] old;
    old = mq;
    if (r) begin
      mq = '0; mc = 1'b0;
    end else if (!e) begin
      mc = 1'b0;
    end else begin
      mc = 1'b0;
      if (m == 3'd1) mq = d;
      if (m == 3'd2) begin mq = (old << 1) | W'(sr); mc = old[W-1]; end
      if (m == 3'd3) begin mq = (old >> 1) | (W'(sl) << (W-1)); mc = old[0]; end
      if (m == 3'd4) begin mq = (old << 1) | (old >> (W-1)); mc = old[W-1]; end
      if (m == 3'd5) begin mq = (old >> 1) | (old << (W-1)); mc = old[0]; end
      if (m == 3'd6) begin mq = W'(int'(old) + 1); mc = (old == 8'hFF); end
      if (m == 3'd7) begin mq = W'(int'(old) + 255); mc = (old == 8'h00); end
    end
  endtask

  initial begin
    exp_t ex;
    int k;

    rst = 1'b1; en = 1'b0; mode = 3'd0; D = '0; sin_r = 1'b0; sin_l = 1'b0;

    k = 0;
    tbl[k++] = mk(1, 1, 3'b001, 8'hFF, 0, 0, 8'h00, 0, 1); // reset beats load
    tbl[k++] = mk(0, 1, 3'b001, 8'hA5, 0, 0, 8'hA5, 0, 0);
    tbl[k++] = mk(0, 1, 3'b010, 8'h00, 1, 0, 8'h4B, 1, 0);
    tbl[k++] = mk(0, 1, 3'b011, 8'hFF, 1, 0, 8'h25, 1, 0);
    tbl[k++] = mk(0, 1, 3'b001, 8'h81, 0, 0, 8'h81, 0, 0);
    tbl[k++] = mk(0, 1, 3'b101, 8'h00, 0, 0, 8'hC0, 1, 0);
    tbl[k++] = mk(0, 1, 3'b101, 8'h00, 1, 1, 8'h60, 0, 0);
    tbl[k++] = mk(0, 1, 3'b101, 8'h00, 0, 0, 8'h30, 0, 0);
    tbl[k++] = mk(0, 1, 3'b101, 8'h00, 0, 0, 8'h18, 0, 0);
    tbl[k++] = mk(0, 1, 3'b101, 8'h00, 0, 0, 8'h0C, 0, 0);
    tbl[k++] = mk(0, 1, 3'b101, 8'h00, 0, 0, 8'h06, 0, 0);
    tbl[k++] = mk(0, 1, 3'b101, 8'h00, 0, 0, 8'h03, 0, 0);
    tbl[k++] = mk(0, 1, 3'b101, 8'h00, 0, 0, 8'h81, 1, 0);
    tbl[k++] = mk(0, 1, 3'b001, 8'hFE, 0, 0, 8'hFE, 0, 0);
    tbl[k++] = mk(0, 1, 3'b110, 8'h00, 0, 0, 8'hFF, 0, 0);
    tbl[k++] = mk(0, 1, 3'b110, 8'h00, 0, 0, 8'h00, 1, 1);
    tbl[k++] = mk(0, 1, 3'b111, 8'h00, 0, 0, 8'hFF, 1, 0);
    tbl[k++] = mk(0, 1, 3'b001, 8'h9E, 0, 0, 8'h9E, 0, 0);
    tbl[k++] = mk(0, 1, 3'b010, 8'hFF, 0, 1, 8'h3C, 1, 0);
    tbl[k++] = mk(0, 0, 3'b110, 8'h00, 0, 0, 8'h3C, 0, 0); // disabled: carry clears
    tbl[k++] = mk(0, 0, 3'b110, 8'hFF, 1, 1, 8'h3C, 0, 0);
    tbl[k++] = mk(0, 0, 3'b110, 8'h00, 0, 0, 8'h3C, 0, 0);
    tbl[k++] = mk(0, 1, 3'b000, 8'hFF, 1, 1, 8'h3C, 0, 0);
    tbl[k++] = mk(0, 1, 3'b100, 8'hFF, 1, 1, 8'h78, 0, 0);
    tbl[k++] = mk(0, 1, 3'b001, 8'h81, 0, 0, 8'h81, 0, 0);
    tbl[k++] = mk(0, 1, 3'b100, 8'h00, 0, 0, 8'h03, 1, 0);
    tbl[k++] = mk(0, 1, 3'b111, 8'h00, 0, 0, 8'h02, 0, 0);
    tbl[k++] = mk(0, 1, 3'b001, 8'h10, 0, 0, 8'h10, 0, 0);
    tbl[k++] = mk(0, 1, 3'b110, 8'h00, 0, 0, 8'h11, 0, 0);
    tbl[k++] = mk(0, 1, 3'b110, 8'h00, 0, 0, 8'h12, 0, 0);
    tbl[k++] = mk(1, 1, 3'b110, 8'h55, 1, 1, 8'h00, 0, 1); // reset mid-count
    tbl[k++] = mk(0, 1, 3'b110, 8'h00, 0, 0, 8'h01, 0, 0);
    tbl[k++] = mk(0, 1, 3'b011, 8'h00, 0, 1, 8'h80, 1, 0);
    tbl[k++] = mk(0, 1, 3'b010, 8'hFF, 1, 0, 8'h01, 1, 0);
    tbl[k++] = mk(0, 1, 3'b010, 8'h00, 0, 0, 8'h02, 0, 0);
    tbl[k++] = mk(1, 0, 3'b001, 8'hAA, 0, 0, 8'h00, 0, 1);

    for (int i = 0; i < NV; i++) begin
      ex.q = tbl[i].eq; ex.c = tbl[i].ec; ex.z = tbl[i].ez;
      apply($sformatf("vec%0d", i), tbl[i].rst, tbl[i].en, tbl[i].mode, tbl[i].d,
            tbl[i].sr, tbl[i].sl, ex);
    end

    // Reset raised and dropped between edges must not disturb Q.
    ex.q = 8'h5A; ex.c = 1'b0; ex.z = 1'b0;
    apply("load5A", 0, 1, 3'b001, 8'h5A, 0, 0, ex);
    ex.q = 8'h5B; ex.c = 1'b0; ex.z = 1'b0;
    apply("up5B", 0, 1, 3'b110, 8'h00, 0, 0, ex);
    @(negedge clk);
    en = 1'b0; mode = 3'b000;
    #1 rst = 1'b1;
    #2;
    check("midcycle_rst.Q", 32'(Q), 32'h5B);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("after_glitch.Q", 32'(Q), 32'h5B);
    check("after_glitch.carry", 32'(carry), 32'h0);

    // Randomized phase against the reference model.
    mq = 8'h5B; mc = 1'b0;
    for (int i = 0; i < 200; i++) begin
      logic r, e, sr, sl;
      logic [2:0] m;
      logic [W-1:0] d;
      r  = ($urandom_range(0, 19) == 0);
      e  = ($urandom_range(0, 4) != 0);
      m  = 3'($urandom_range(0, 7));
      d  = 8'($urandom);
      sr = 1'($urandom);
      sl = 1'($urandom);
      model_step(r, e, m, d, sr, sl);
      ex.q = mq; ex.c = mc; ex.z = (mq == 8'h00);
      apply($sformatf("rnd%0d", i), r, e, m, d, sr, sl, ex);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
